fpu_result_wb: RTL and testbench

- Writeback stage directly downstream of the single-cycle FP execute block.
- Takes that block's per-op result buses (arithmetic, 32/64-bit convert, compare, class) and exception flags.
- Formats them into one XLEN-wide writeback word tagged FP or integer destination, and buffers it in a 2-entry valid/ready skid queue.
- Accrues retired exception flags into the sticky fflags register, which has a CSR write port.

---
 rtl/fpu_result_wb.sv | 177 +++++++++++++++++
 tb/tb_fpu_result_wb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_wb.sv
// fpu_result_wb: FP writeback stage. Formats execute results into one
// XLEN-wide writeback word, buffers it in a 2-entry skid queue and accrues
// retired exception flags into the sticky fflags register.
// Optional: FPU_RESULT_WB_NANBOX_EN fills FP-destination upper bits with ones.
module fpu_result_wb #(
   parameter int XLEN = 64,
   parameter int FLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      in_ftype,
   input  logic [4:0]      in_rd,
   input  logic [FLEN-1:0] in_farith,
   input  logic [31:0]     in_wcvt,
   input  logic [63:0]     in_lcvt,
   input  logic            in_fcmp,
   input  logic [XLEN-1:0] in_fclass,
   input  logic [4:0]      in_flags,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_is_int,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_data,
   output logic            illegal_op,
   output logic [4:0]      fflags,
   input  logic            csr_we,
   input  logic [4:0]      csr_wdata
);

   typedef enum logic [2:0] {
      FMT_FP, FMT_W, FMT_L, FMT_CMP, FMT_CLASS, FMT_ILL
   } fmt_e;

   fmt_e            fmt;
   logic            fmt_is_int;
   logic [XLEN-1:0] fmt_data;
   logic [4:0]      fmt_flags;

   logic            is_int_q [2];
   logic            is_int_d [2];
   logic [4:0]      rd_q     [2];
   logic [4:0]      rd_d     [2];
   logic [XLEN-1:0] data_q   [2];
   logic [XLEN-1:0] data_d   [2];
   logic [4:0]      flags_q  [2];
   logic [4:0]      flags_d  [2];
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic [1:0]      count_q, count_d;
   logic            in_ready_q, in_ready_d;
   logic            illegal_q, illegal_d;
   logic [4:0]      fflags_q, fflags_d;
   logic            accept, enq, deq;

   // Classify the op code into a result format.
   always_comb begin
      fmt = FMT_ILL;
      case (in_ftype) inside
         [5'd0:5'd8], [5'd13:5'd17]: fmt = FMT_FP;
         [5'd9:5'd10]:               fmt = FMT_W;
         [5'd11:5'd12]:              fmt = FMT_L;
         [5'd18:5'd20]:              fmt = FMT_CMP;
         5'd21:                      fmt = FMT_CLASS;
         default:                    fmt = FMT_ILL;
      endcase
   end

   // Build the writeback word and flags for the incoming result.
   always_comb begin
      fmt_is_int = 1'b1;
      fmt_data   = '0;
      fmt_flags  = in_flags;
      case (fmt)
         FMT_FP: begin
            fmt_is_int = 1'b0;
`ifdef FPU_RESULT_WB_NANBOX_EN
            fmt_data = '1;
`else
            fmt_data = '0;
`endif
            fmt_data[FLEN-1:0] = in_farith;
         end
         FMT_W: begin
            // RV64: the unsigned 32-bit convert is sign-extended as well.
            fmt_data       = {XLEN{in_wcvt[31]}};
            fmt_data[31:0] = in_wcvt;
         end
         FMT_L:     fmt_data = XLEN'(in_lcvt);
         FMT_CMP:   fmt_data[0] = in_fcmp;
         FMT_CLASS: begin
            fmt_data  = in_fclass;
            fmt_flags = '0;
         end
         default: ;
      endcase
   end

   // Queue control, illegal detection and fflags next-state.
   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         is_int_d[i] = is_int_q[i];
         rd_d[i]     = rd_q[i];
         data_d[i]   = data_q[i];
         flags_d[i]  = flags_q[i];
      end
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      accept    = in_valid && in_ready_q && !flush;
      enq       = accept && (fmt != FMT_ILL);
      deq       = (count_q != 2'd0) && out_ready;
      illegal_d = accept && (fmt == FMT_ILL);
      if (flush) begin
         count_d  = '0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (enq) begin
            is_int_d[wr_ptr_q] = fmt_is_int;
            rd_d[wr_ptr_q]     = in_rd;
            data_d[wr_ptr_q]   = fmt_data;
            flags_d[wr_ptr_q]  = fmt_flags;
            wr_ptr_d           = !wr_ptr_q;
         end
         if (deq) rd_ptr_d = !rd_ptr_q;
         if (enq && !deq)      count_d = count_q + 2'd1;
         else if (!enq && deq) count_d = count_q - 2'd1;
      end
      // Registered from the next count so out_ready never reaches in_ready.
      in_ready_d = (count_d != 2'd2);
      fflags_d   = (csr_we ? csr_wdata : fflags_q)
                 | ((deq && !flush) ? flags_q[rd_ptr_q] : 5'd0);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) begin
            is_int_q[i] <= 1'b0;
            rd_q[i]     <= '0;
            data_q[i]   <= '0;
            flags_q[i]  <= '0;
         end
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= '0;
         in_ready_q <= 1'b1;
         illegal_q  <= 1'b0;
         fflags_q   <= '0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            is_int_q[i] <= is_int_d[i];
            rd_q[i]     <= rd_d[i];
            data_q[i]   <= data_d[i];
            flags_q[i]  <= flags_d[i];
         end
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
         illegal_q  <= illegal_d;
         fflags_q   <= fflags_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = (count_q != 2'd0);
   assign out_is_int = is_int_q[rd_ptr_q];
   assign out_rd     = rd_q[rd_ptr_q];
   assign out_data   = data_q[rd_ptr_q];
   assign illegal_op = illegal_q;
   assign fflags     = fflags_q;

endmodule

// File: tb/tb_fpu_result_wb.sv
// Self-checking bench for fpu_result_wb: vector table, hand sequences for
// backpressure / CSR / flush / illegal / async reset, and a random phase
// compared against a queue-based reference model.
module tb_fpu_result_wb;
   localparam int XLEN = 64;
   localparam int FLEN = 32;
`ifdef FPU_RESULT_WB_NANBOX_EN
   localparam logic [31:0] NB = 32'hFFFFFFFF;
`else
   localparam logic [31:0] NB = 32'h00000000;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid, in_ready, in_fcmp, flush, out_valid, out_ready;
   logic            out_is_int, illegal_op, csr_we;
   logic [4:0]      in_ftype, in_rd, in_flags, out_rd, fflags, csr_wdata;
   logic [FLEN-1:0] in_farith;
   logic [31:0]     in_wcvt;
   logic [63:0]     in_lcvt;
   logic [XLEN-1:0] in_fclass, out_data;

   always #5 clk = ~clk;

   fpu_result_wb #(.XLEN(XLEN), .FLEN(FLEN)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_ftype(in_ftype), .in_rd(in_rd), .in_farith(in_farith),
      .in_wcvt(in_wcvt), .in_lcvt(in_lcvt), .in_fcmp(in_fcmp),
      .in_fclass(in_fclass), .in_flags(in_flags), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_is_int(out_is_int),
      .out_rd(out_rd), .out_data(out_data), .illegal_op(illegal_op),
      .fflags(fflags), .csr_we(csr_we), .csr_wdata(csr_wdata)
   );

   typedef struct {
      logic        is_int;
      logic [4:0]  rd;
      logic [63:0] data;
      logic [4:0]  flags;
   } ent_t;

   typedef struct {
      logic [4:0]  ftype, rd, flags;
      logic [31:0] farith, wcvt;
      logic [63:0] lcvt, fclass, exp_data;
      logic        fcmp, exp_valid, exp_int, exp_ill;
   } vec_t;

   ent_t       mq[$];
   logic       m_ill = 1'b0;
   logic [4:0] m_ff  = 5'd0;
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: what the spec says the current input should become.
   task automatic model_fmt(output logic legal, output ent_t e);
      legal    = 1'b1;
      e.rd     = in_rd;
      e.flags  = in_flags;
      e.is_int = 1'b1;
      e.data   = 64'd0;
      if (in_ftype <= 8 || (in_ftype >= 13 && in_ftype <= 17)) begin
         e.is_int = 1'b0;
         e.data   = {NB, in_farith};
      end else if (in_ftype == 9 || in_ftype == 10)
         e.data = {{32{in_wcvt[31]}}, in_wcvt};
      else if (in_ftype == 11 || in_ftype == 12)
         e.data = in_lcvt;
      else if (in_ftype >= 18 && in_ftype <= 20)
         e.data = {63'd0, in_fcmp};
      else if (in_ftype == 21) begin
         e.data  = in_fclass;
         e.flags = 5'd0;
      end else
         legal = 1'b0;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".in_ready"},   64'(in_ready),   64'(mq.size() < 2));
      check({tag, ".out_valid"},  64'(out_valid),  64'(mq.size() > 0));
      if (mq.size() > 0) begin
         check({tag, ".out_is_int"}, 64'(out_is_int), 64'(mq[0].is_int));
         check({tag, ".out_rd"},     64'(out_rd),     64'(mq[0].rd));
         check({tag, ".out_data"},   out_data,        mq[0].data);
      end
      check({tag, ".illegal_op"}, 64'(illegal_op), 64'(m_ill));
      check({tag, ".fflags"},     64'(fflags),     64'(m_ff));
   endtask

   // Advance one clock: update the model from current inputs, then compare.
   task automatic step(input string tag);
      logic       legal, rdy, deq;
      ent_t       e;
      logic [4:0] ffn;
      model_fmt(legal, e);
      rdy = (mq.size() < 2);
      deq = (mq.size() > 0) && out_ready;
      ffn = csr_we ? csr_wdata : m_ff;
      if (deq && !flush) ffn = ffn | mq[0].flags;
      m_ill = in_valid && rdy && !legal && !flush;
      if (flush) mq.delete();
      else begin
         if (deq) void'(mq.pop_front());
         if (in_valid && rdy && legal) mq.push_back(e);
      end
      m_ff = ffn;
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic idle();
      in_valid = 0; in_ftype = 0; in_rd = 0; in_farith = 0; in_wcvt = 0;
      in_lcvt = 0; in_fcmp = 0; in_fclass = 0; in_flags = 0; flush = 0;
      out_ready = 0; csr_we = 0; csr_wdata = 0;
   endtask

   task automatic drive_fp(input logic [4:0] rd, input logic [4:0] fl);
      in_valid = 1; in_ftype = 5'd0; in_rd = rd; in_farith = 32'h40000000 + 32'(rd);
      in_flags = fl;
   endtask

   function automatic vec_t mk(input logic [4:0] ft, input logic [4:0] rd,
                               input logic [31:0] fa, input logic [31:0] wc,
                               input logic [63:0] lc, input logic fc,
                               input logic [63:0] fcl, input logic [4:0] fl,
                               input logic ev, input logic ei, input logic [63:0] ed,
                               input logic eil);
      vec_t v;
      v.ftype = ft; v.rd = rd; v.farith = fa; v.wcvt = wc; v.lcvt = lc; v.fcmp = fc;
      v.fclass = fcl; v.flags = fl; v.exp_valid = ev; v.exp_int = ei; v.exp_data = ed;
      v.exp_ill = eil;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t       vt[10];
      logic [4:0] seen[$];
      logic [4:0] ff_saved;

      vt[0] = mk(5'd0,  5'd3,  32'h3F800000, 0, 0, 0, 0, 5'b00001, 1, 0, {NB, 32'h3F800000}, 0);
      vt[1] = mk(5'd10, 5'd5,  0, 32'h80000000, 0, 0, 0, 5'b00010, 1, 1, 64'hFFFFFFFF80000000, 0);
      vt[2] = mk(5'd9,  5'd6,  0, 32'h7FFFFFFF, 0, 0, 0, 5'b00000, 1, 1, 64'h000000007FFFFFFF, 0);
      vt[3] = mk(5'd11, 5'd7,  0, 0, 64'h8000000000000001, 0, 0, 5'b00100, 1, 1, 64'h8000000000000001, 0);
      vt[4] = mk(5'd19, 5'd8,  0, 0, 0, 1, 0, 5'b00000, 1, 1, 64'd1, 0);
      vt[5] = mk(5'd21, 5'd9,  0, 0, 0, 0, 64'h200, 5'b11111, 1, 1, 64'h200, 0);
      vt[6] = mk(5'd17, 5'd10, 32'hC0000000, 0, 0, 0, 0, 5'b01000, 1, 0, {NB, 32'hC0000000}, 0);
      vt[7] = mk(5'd25, 5'd11, 0, 0, 0, 0, 0, 5'b10000, 0, 0, 64'd0, 1);
      vt[8] = mk(5'd22, 5'd12, 0, 0, 0, 0, 0, 5'b10000, 0, 0, 64'd0, 1);
      vt[9] = mk(5'd31, 5'd13, 0, 0, 0, 0, 0, 5'b10000, 0, 0, 64'd0, 1);

      // Reset
      idle();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      #1;
      check("reset.out_valid",  64'(out_valid),  64'd0);
      check("reset.in_ready",   64'(in_ready),   64'd1);
      check("reset.fflags",     64'(fflags),     64'd0);
      check("reset.out_data",   out_data,        64'd0);
      check("reset.out_rd",     64'(out_rd),     64'd0);
      check("reset.out_is_int", 64'(out_is_int), 64'd0);
      check("reset.illegal_op", 64'(illegal_op), 64'd0);

      // Vector table: each op from an empty queue, then retire it.
      for (int i = 0; i < 10; i++) begin
         in_valid = 1; in_ftype = vt[i].ftype; in_rd = vt[i].rd; in_farith = vt[i].farith;
         in_wcvt = vt[i].wcvt; in_lcvt = vt[i].lcvt; in_fcmp = vt[i].fcmp;
         in_fclass = vt[i].fclass; in_flags = vt[i].flags; out_ready = 1;
         step("vec");
         check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(vt[i].exp_valid));
         check($sformatf("vec%0d.illegal", i), 64'(illegal_op), 64'(vt[i].exp_ill));
         if (vt[i].exp_valid) begin
            check($sformatf("vec%0d.is_int", i), 64'(out_is_int), 64'(vt[i].exp_int));
            check($sformatf("vec%0d.rd", i), 64'(out_rd), 64'(vt[i].rd));
            check($sformatf("vec%0d.data", i), out_data, vt[i].exp_data);
         end
         in_valid = 0;
         step("vec_retire");
         if (i == 0) check("vec0.fflags_after_retire", 64'(fflags), 64'b00001);
      end

      // Backpressure: three back-to-back results with out_ready low.
      idle();
      drive_fp(5'd1, 5'd0); step("bp1");
      drive_fp(5'd2, 5'd0); step("bp2");
      check("bp.in_ready_full", 64'(in_ready), 64'd0);
      drive_fp(5'd3, 5'd0);
      out_ready = 1;
      for (int c = 0; c < 10; c++) begin
         if (c == 2) in_valid = 0;
         if (out_valid && out_ready) seen.push_back(out_rd);
         step("bp_drain");
      end
      check("bp.count", 64'(seen.size()), 64'd3);
      for (int k = 0; k < 3 && k < seen.size(); k++)
         check($sformatf("bp.order%0d", k), 64'(seen[k]), 64'(k + 1));

      // CSR write coinciding with a retire.
      idle();
      csr_we = 1; csr_wdata = 5'd0; step("csr_clr");
      csr_we = 0; drive_fp(5'd4, 5'b10000); step("csr_enq");
      in_valid = 0; csr_we = 1; csr_wdata = 5'b00100; out_ready = 1;
      step("csr_retire");
      check("csr.fflags", 64'(fflags), 64'b10100);

      // Flush with two queued entries and a retiring head.
      idle();
      drive_fp(5'd5, 5'b00011); step("fl_enq1");
      drive_fp(5'd6, 5'b00011); step("fl_enq2");
      flush = 1; out_ready = 1; drive_fp(5'd7, 5'b01000);
      step("flush");
      check("flush.out_valid", 64'(out_valid), 64'd0);
      check("flush.fflags", 64'(fflags), 64'b10100);
      idle(); step("flush_after");
      check("flush.stays_empty", 64'(out_valid), 64'd0);

      // Illegal op pulse.
      in_valid = 1; in_ftype = 5'd25; in_flags = 5'b00001; step("ill");
      check("ill.pulse", 64'(illegal_op), 64'd1);
      check("ill.no_enq", 64'(out_valid), 64'd0);
      idle(); step("ill_after");
      check("ill.one_cycle", 64'(illegal_op), 64'd0);
      check("ill.fflags", 64'(fflags), 64'b10100);

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_ftype  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(22, 31))
                                                 : 5'($urandom_range(0, 21));
         in_rd     = 5'($urandom);
         in_farith = $urandom;
         in_wcvt   = $urandom;
         in_lcvt   = {$urandom, $urandom};
         in_fcmp   = 1'($urandom);
         in_fclass = {$urandom, $urandom};
         in_flags  = 5'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         csr_we    = ($urandom_range(0, 15) == 0);
         csr_wdata = 5'($urandom);
         step("rand");
      end

      // Asynchronous reset mid-transfer.
      idle();
      drive_fp(5'd8, 5'b00110); step("rst_enq1");
      drive_fp(5'd9, 5'b00110); step("rst_enq2");
      #2 rst_n = 0;
      #1;
      check("arst.out_valid", 64'(out_valid), 64'd0);
      check("arst.in_ready",  64'(in_ready),  64'd1);
      check("arst.fflags",    64'(fflags),    64'd0);
      check("arst.out_data",  out_data,       64'd0);
      mq.delete(); m_ill = 0; m_ff = 0;
      @(posedge clk);
      #1 rst_n = 1;
      idle(); out_ready = 1;
      step("arst_after");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
